// File: rtl/hdmi_video_timing_gen_if.sv
// Frame-buffer read port between the timing generator and pixel memory.
// master: mem_rd/mem_addr out, mem_data in; slave: mirror of master.
interface hdmi_video_timing_gen_if #(
  parameter int ADDR_W = 19
);
  logic              mem_rd;
  logic [ADDR_W-1:0] mem_addr;
  logic [11:0]       mem_data;

  modport master (
    output mem_rd,
    output mem_addr,
    input  mem_data
  );

  modport slave (
    input  mem_rd,
    input  mem_addr,
    output mem_data
  );
endinterface

// File: rtl/hdmi_video_timing_gen.sv
// HDMI/DVI raster timing generator with frame-buffer read port.
// Ports: clk, rst (async, active-high), frame_sync (re-lock pulse),
//   mem (read port: mem_rd, mem_addr, mem_data RGB444),
//   out_data (RGB888), out_hsync, out_vsync, out_de, frame_start,
//   dbg_h_cnt, dbg_v_cnt.
// Optional: define HDMI_TPG_EN to add tpg_sel and a colour-bar pattern.
module hdmi_video_timing_gen #(
  parameter int H_ACTIVE    = 640,
  parameter int H_FP        = 16,
  parameter int H_SYNC      = 96,
  parameter int H_BP        = 48,
  parameter int V_ACTIVE    = 480,
  parameter int V_FP        = 10,
  parameter int V_SYNC      = 2,
  parameter int V_BP        = 33,
  parameter int SYNC_POL    = 0,
  parameter int SCALE_SHIFT = 0,
  parameter int MEM_LAT     = 1,
  parameter int ADDR_W      = 19
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_sync,
`ifdef HDMI_TPG_EN
  input  logic        tpg_sel,
`endif
  hdmi_video_timing_gen_if.master mem,
  output logic [23:0] out_data,
  output logic        out_hsync,
  output logic        out_vsync,
  output logic        out_de,
  output logic        frame_start,
  output logic [15:0] dbg_h_cnt,
  output logic [15:0] dbg_v_cnt
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int P       = MEM_LAT + 1;

  localparam logic [15:0] H_ACT = 16'(H_ACTIVE);
  localparam logic [15:0] V_ACT = 16'(V_ACTIVE);
  localparam logic [15:0] H_END = 16'(H_TOTAL - 1);
  localparam logic [15:0] V_END = 16'(V_TOTAL - 1);
  localparam logic [15:0] HS_B  = 16'(H_ACTIVE + H_FP);
  localparam logic [15:0] HS_E  = 16'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [15:0] VS_B  = 16'(V_ACTIVE + V_FP);
  localparam logic [15:0] VS_E  = 16'(V_ACTIVE + V_FP + V_SYNC - 1);
  localparam logic [15:0] V_MSK = 16'((1 << SCALE_SHIFT) - 1);
  localparam logic        POL   = 1'(SYNC_POL);

  localparam logic [ADDR_W-1:0] ROW_STEP =
    ADDR_W'(H_ACTIVE >> SCALE_SHIFT);

  logic [15:0]       h_cnt;
  logic [15:0]       v_cnt;
  logic [ADDR_W-1:0] row_base;
  logic              h_wrap;
  logic              at_end;
  logic              relock;
  logic              act;
  logic              hs0;
  logic              vs0;
  logic [P-1:0]      de_pipe;
  logic [P-1:0]      hs_pipe;
  logic [P-1:0]      vs_pipe;
  logic              data_de;
  logic [23:0]       pix;
  logic [23:0]       mem_pix;

  assign h_wrap = (h_cnt == H_END);
  assign at_end = h_wrap && (v_cnt == V_END);
  // Already parked on the last pixel: let it wrap normally.
  assign relock = frame_sync && !at_end;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (relock) begin
      h_cnt <= H_END;
      v_cnt <= V_END;
    end else if (h_wrap) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_END) ? '0 : v_cnt + 16'd1;
    end else begin
      h_cnt <= h_cnt + 16'd1;
    end
  end

  // Row base steps once per replicated group of lines.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      row_base <= '0;
    end else if (relock || at_end) begin
      row_base <= '0;
    end else if (h_wrap && (v_cnt < V_ACT) &&
                 ((v_cnt & V_MSK) == V_MSK)) begin
      row_base <= row_base + ROW_STEP;
    end
  end

  // Stage-0 qualifiers are held off while rst is high.
  assign act = !rst && (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hs0 = (h_cnt >= HS_B) && (h_cnt <= HS_E);
  assign vs0 = (v_cnt >= VS_B) && (v_cnt <= VS_E);
  assign frame_start = !rst && (h_cnt == '0) && (v_cnt == '0);

`ifdef HDMI_TPG_EN
  assign mem.mem_rd = act && !tpg_sel;
`else
  assign mem.mem_rd = act;
`endif
  assign mem.mem_addr = row_base + ADDR_W'(h_cnt >> SCALE_SHIFT);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      de_pipe <= '0;
      hs_pipe <= '0;
      vs_pipe <= '0;
    end else begin
      de_pipe <= {de_pipe[P-2:0], act};
      hs_pipe <= {hs_pipe[P-2:0], hs0};
      vs_pipe <= {vs_pipe[P-2:0], vs0};
    end
  end

  // Qualifier for the cycle in which mem_data is valid.
  assign data_de = de_pipe[MEM_LAT-1];

  assign mem_pix = {mem.mem_data[11:8], mem.mem_data[11:8],
                    mem.mem_data[7:4],  mem.mem_data[7:4],
                    mem.mem_data[3:0],  mem.mem_data[3:0]};

`ifdef HDMI_TPG_EN
  localparam logic [15:0] BAR_W = 16'(H_ACTIVE / 8);

  logic [2:0]  bar_idx;
  logic [15:0] bar_px;
  logic [23:0] bar_rgb;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bar_idx <= '0;
      bar_px  <= '0;
    end else if (!data_de) begin
      bar_idx <= '0;
      bar_px  <= '0;
    end else if (bar_px == BAR_W - 16'd1) begin
      bar_idx <= bar_idx + 3'd1;
      bar_px  <= '0;
    end else begin
      bar_px  <= bar_px + 16'd1;
    end
  end

  always_comb begin
    bar_rgb = 24'h000000;
    unique case (bar_idx)
      3'd0: bar_rgb = 24'hFFFFFF;
      3'd1: bar_rgb = 24'hFFFF00;
      3'd2: bar_rgb = 24'h00FFFF;
      3'd3: bar_rgb = 24'h00FF00;
      3'd4: bar_rgb = 24'hFF00FF;
      3'd5: bar_rgb = 24'hFF0000;
      3'd6: bar_rgb = 24'h0000FF;
      3'd7: bar_rgb = 24'h000000;
    endcase
  end

  assign pix = tpg_sel ? bar_rgb : mem_pix;
`else
  assign pix = mem_pix;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data <= '0;
    end else begin
      out_data <= data_de ? pix : 24'h000000;
    end
  end

  assign out_de    = de_pipe[P-1];
  assign out_hsync = hs_pipe[P-1] ^ ~POL;
  assign out_vsync = vs_pipe[P-1] ^ ~POL;
  assign dbg_h_cnt = h_cnt;
  assign dbg_v_cnt = v_cnt;

endmodule

// File: tb/tb_hdmi_video_timing_gen.sv
// Directed bench for hdmi_video_timing_gen: default 640x480 timing,
// a small raster with MEM_LAT=3 and a small raster with SCALE_SHIFT=1.
module tb_hdmi_video_timing_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic fs  = 1'b0;

  logic        ovr     = 1'b0;
  logic [11:0] ovr_val = 12'h000;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hdmi_video_timing_gen_if #(.ADDR_W(19)) if_def ();
  hdmi_video_timing_gen_if #(.ADDR_W(19)) if_l3 ();
  hdmi_video_timing_gen_if #(.ADDR_W(19)) if_s1 ();

  logic [23:0] d_data, l_data, s_data;
  logic d_hs, d_vs, d_de, d_fs;
  logic l_hs, l_vs, l_de, l_fs;
  logic s_hs, s_vs, s_de, s_fs;
  logic [15:0] d_h, d_v, l_h, l_v, s_h, s_v;

  // Memory model for the MEM_LAT=3 instance: data = address + 1.
  logic [18:0] q1 = '0, q2 = '0, q3 = '0;
  always @(posedge clk) begin
    q1 <= if_l3.mem_addr;
    q2 <= q1;
    q3 <= q2;
  end
  assign if_l3.mem_data = ovr ? ovr_val : 12'(q3 + 19'd1);
  assign if_def.mem_data = 12'h123;
  assign if_s1.mem_data = 12'h000;

  hdmi_video_timing_gen u_def (
    .clk(clk), .rst(rst), .frame_sync(fs), .mem(if_def),
    .out_data(d_data), .out_hsync(d_hs), .out_vsync(d_vs),
    .out_de(d_de), .frame_start(d_fs),
    .dbg_h_cnt(d_h), .dbg_v_cnt(d_v)
  );

  hdmi_video_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .MEM_LAT(3)
  ) u_l3 (
    .clk(clk), .rst(rst), .frame_sync(fs), .mem(if_l3),
    .out_data(l_data), .out_hsync(l_hs), .out_vsync(l_vs),
    .out_de(l_de), .frame_start(l_fs),
    .dbg_h_cnt(l_h), .dbg_v_cnt(l_v)
  );

  hdmi_video_timing_gen #(
    .H_ACTIVE(16), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(8), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .SCALE_SHIFT(1), .MEM_LAT(1)
  ) u_s1 (
    .clk(clk), .rst(rst), .frame_sync(fs), .mem(if_s1),
    .out_data(s_data), .out_hsync(s_hs), .out_vsync(s_vs),
    .out_de(s_de), .frame_start(s_fs),
    .dbg_h_cnt(s_h), .dbg_v_cnt(s_v)
  );

  // Leaves the bench 1 time unit after the release negedge (cycle 0).
  task automatic do_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (l_de !== 1'b0 || l_data !== 24'h0) begin
      errors++;
      $display("FAIL rst_de_data: de=%b data=%h want 0/0", l_de, l_data);
    end
    checks++;
    if (l_hs !== 1'b1 || l_vs !== 1'b1) begin
      errors++;
      $display("FAIL rst_sync: hs=%b vs=%b want 1/1", l_hs, l_vs);
    end
    checks++;
    if (l_fs !== 1'b0 || if_l3.mem_rd !== 1'b0 ||
        if_l3.mem_addr !== 19'd0) begin
      errors++;
      $display("FAIL rst_stage0: fs=%b rd=%b addr=%0d want 0/0/0",
               l_fs, if_l3.mem_rd, if_l3.mem_addr);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (l_fs !== 1'b1 || if_l3.mem_rd !== 1'b1 || l_h !== 16'd0) begin
      errors++;
      $display("FAIL rst_release: fs=%b rd=%b h=%0d want 1/1/0",
               l_fs, if_l3.mem_rd, l_h);
    end
  endtask

  task automatic test_latency();
    do_reset();
    for (int c = 0; c < 6; c++) begin
      checks++;
      if (l_de !== (c >= 4)) begin
        errors++;
        $display("FAIL lat_de c=%0d: de=%b want %b", c, l_de, c >= 4);
      end
      if (c == 3) begin
        checks++;
        if (if_l3.mem_addr !== 19'd3) begin
          errors++;
          $display("FAIL lat_addr: addr=%0d want 3", if_l3.mem_addr);
        end
      end
      if (c == 4) begin
        checks++;
        if (l_data !== 24'h000011) begin
          errors++;
          $display("FAIL lat_first: data=%h want 000011", l_data);
        end
      end
      if (c == 5) begin
        checks++;
        if (l_data !== 24'h000022) begin
          errors++;
          $display("FAIL lat_second: data=%h want 000022", l_data);
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic test_expand();
    ovr = 1'b1;
    ovr_val = 12'hF30;
    do_reset();
    for (int c = 0; c < 23; c++) begin
      if (c == 5) begin
        checks++;
        if (l_de !== 1'b1 || l_data !== 24'hFF3300) begin
          errors++;
          $display("FAIL exp_f30: de=%b data=%h want 1/ff3300",
                   l_de, l_data);
        end
        ovr_val = 12'hFFF;
      end
      if (c == 19) begin
        checks++;
        if (l_de !== 1'b1 || l_data !== 24'hFFFFFF) begin
          errors++;
          $display("FAIL exp_fff: de=%b data=%h want 1/ffffff",
                   l_de, l_data);
        end
      end
      if (c == 22) begin
        checks++;
        if (l_de !== 1'b0 || l_data !== 24'h0) begin
          errors++;
          $display("FAIL exp_blank: de=%b data=%h want 0/000000",
                   l_de, l_data);
        end
      end
      @(negedge clk);
    end
    ovr = 1'b0;
  endtask

  task automatic test_scale();
    int cyc [8] = '{2, 3, 15, 24, 39, 48, 183, 288};
    int adr [8] = '{1, 1, 7, 0, 7, 8, 31, 0};
    int c = 0;
    do_reset();
    for (int i = 0; i < 8; i++) begin
      while (c < cyc[i]) begin
        @(negedge clk);
        c++;
        if (c == 16) begin
          checks++;
          if (if_s1.mem_rd !== 1'b0) begin
            errors++;
            $display("FAIL scale_rd_blank: rd=%b want 0", if_s1.mem_rd);
          end
        end
      end
      checks++;
      if (if_s1.mem_rd !== 1'b1 || if_s1.mem_addr !== 19'(adr[i])) begin
        errors++;
        $display("FAIL scale_addr c=%0d: rd=%b addr=%0d want 1/%0d",
                 c, if_s1.mem_rd, if_s1.mem_addr, adr[i]);
      end
    end
  endtask

  task automatic test_timing();
    int f1 = -1, f2 = -1, hlow = 0, dde = 0;
    int v1 = -1, v2 = -1, vlow = 0, lde = 0;
    logic ph = 1'b1, pv = 1'b1;
    do_reset();
    for (int c = 0; c < 1700; c++) begin
      if (ph && !d_hs) begin
        if (f1 < 0) f1 = c;
        else if (f2 < 0) f2 = c;
      end
      if (f1 >= 0 && f2 < 0) begin
        if (!d_hs) hlow++;
        if (d_de) dde++;
      end
      if (pv && !l_vs) begin
        if (v1 < 0) v1 = c;
        else if (v2 < 0) v2 = c;
      end
      if (v1 >= 0 && v2 < 0) begin
        if (!l_vs) vlow++;
        if (l_de) lde++;
      end
      ph = d_hs;
      pv = l_vs;
      @(negedge clk);
    end
    checks++;
    if (f1 != 658) begin
      errors++;
      $display("FAIL hs_first: at %0d want 658", f1);
    end
    checks++;
    if (f2 - f1 != 800 || f2 < 0) begin
      errors++;
      $display("FAIL hs_period: %0d want 800", f2 - f1);
    end
    checks++;
    if (hlow != 96) begin
      errors++;
      $display("FAIL hs_width: %0d want 96", hlow);
    end
    checks++;
    if (dde != 640) begin
      errors++;
      $display("FAIL de_per_line: %0d want 640", dde);
    end
    checks++;
    if (v1 != 220 || v2 - v1 != 288 || v2 < 0) begin
      errors++;
      $display("FAIL vs_period: first=%0d period=%0d want 220/288",
               v1, v2 - v1);
    end
    checks++;
    if (vlow != 48) begin
      errors++;
      $display("FAIL vs_width: %0d want 48", vlow);
    end
    checks++;
    if (lde != 128) begin
      errors++;
      $display("FAIL de_per_frame: %0d want 128", lde);
    end
  endtask

  task automatic test_frame_sync();
    do_reset();
    repeat (127) @(negedge clk);
    fs = 1'b1;
    @(negedge clk);
    fs = 1'b0;
    checks++;
    if (l_h !== 16'd23 || l_v !== 16'd11 || if_l3.mem_rd !== 1'b0 ||
        l_fs !== 1'b0) begin
      errors++;
      $display("FAIL fsync_park: h=%0d v=%0d rd=%b fs=%b want 23/11/0/0",
               l_h, l_v, if_l3.mem_rd, l_fs);
    end
    @(negedge clk);
    checks++;
    if (l_fs !== 1'b1 || if_l3.mem_addr !== 19'd0 ||
        if_l3.mem_rd !== 1'b1) begin
      errors++;
      $display("FAIL fsync_start: fs=%b addr=%0d rd=%b want 1/0/1",
               l_fs, if_l3.mem_addr, if_l3.mem_rd);
    end
    repeat (287) @(negedge clk);
    checks++;
    if (l_h !== 16'd23 || l_v !== 16'd11) begin
      errors++;
      $display("FAIL fsync_end: h=%0d v=%0d want 23/11", l_h, l_v);
    end
    fs = 1'b1;
    @(negedge clk);
    fs = 1'b0;
    checks++;
    if (l_fs !== 1'b1 || l_h !== 16'd0 || l_v !== 16'd0) begin
      errors++;
      $display("FAIL fsync_noextra: fs=%b h=%0d v=%0d want 1/0/0",
               l_fs, l_h, l_v);
    end
    @(negedge clk);
    checks++;
    if (l_fs !== 1'b0 || l_h !== 16'd1) begin
      errors++;
      $display("FAIL fsync_run: fs=%b h=%0d want 0/1", l_fs, l_h);
    end
  endtask

  task automatic test_mid_reset();
    do_reset();
    repeat (30) @(negedge clk);
    checks++;
    if (l_de !== 1'b1) begin
      errors++;
      $display("FAIL mid_pre_de: de=%b want 1", l_de);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (l_de !== 1'b0 || l_data !== 24'h0 || l_hs !== 1'b1 ||
        if_l3.mem_rd !== 1'b0 || l_fs !== 1'b0 ||
        l_h !== 16'd0 || l_v !== 16'd0) begin
      errors++;
      $display("FAIL mid_rst: de=%b data=%h hs=%b rd=%b fs=%b h=%0d v=%0d",
               l_de, l_data, l_hs, if_l3.mem_rd, l_fs, l_h, l_v);
    end
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    checks++;
    if (l_fs !== 1'b1 || l_h !== 16'd0 || if_l3.mem_rd !== 1'b1) begin
      errors++;
      $display("FAIL mid_release: fs=%b h=%0d rd=%b want 1/0/1",
               l_fs, l_h, if_l3.mem_rd);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (l_de !== 1'b0 || if_l3.mem_addr !== 19'd2) begin
      errors++;
      $display("FAIL mid_flush: de=%b addr=%0d want 0/2",
               l_de, if_l3.mem_addr);
    end
  endtask

  initial begin
    test_reset();
    test_latency();
    test_expand();
    test_scale();
    test_timing();
    test_frame_sync();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hdmi_video_timing_gen.md
# hdmi_video_timing_gen

Parametrised HDMI/DVI raster timing generator with frame-buffer read port. It sits between the camera frame buffer and the HDMI encoder, in the pixel clock domain. It produces hsync, vsync and data-enable for any CEA/VESA mode, and issues linear read addresses with optional 2^N pixel/line replication. Read data is re-aligned to the syncs across a configurable memory latency, and an external frame-sync pulse re-locks the raster.

## Interface
- H_ACTIVE, 640, active pixels per line
- H_FP, 16, horizontal front porch (pixels)
- H_SYNC, 96, hsync width (pixels)
- H_BP, 48, horizontal back porch (pixels)
- V_ACTIVE, 480, active lines per frame
- V_FP, 10, vertical front porch (lines)
- V_SYNC, 2, vsync width (lines)
- V_BP, 33, vertical back porch (lines)
- SYNC_POL, 0, sync asserted level (0 = active-low)
- SCALE_SHIFT, 0, replication factor 2^SCALE_SHIFT in both axes (0..2)
- MEM_LAT, 1, mem_rd to mem_data latency in cycles (1..4)
- ADDR_W, 19, read address width
- clk  in  1  pixel clock; the only clock
- rst  in  1  reset, asynchronous and active-high
- frame_sync  in  1  single-cycle re-lock request
- mem_rd  out  1  read strobe
- mem_addr  out  ADDR_W  pixel address
- mem_data  in  12  RGB444 pixel, valid MEM_LAT cycles after mem_rd
- out_data  out  24  RGB888 to encoder
- out_hsync  out  1  horizontal sync
- out_vsync  out  1  vertical sync
- out_de  out  1  data enable
- frame_start  out  1  one-cycle pulse at h_cnt=0, v_cnt=0
- dbg_h_cnt  out  16  raw horizontal counter
- dbg_v_cnt  out  16  raw vertical counter

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL is formed the same way.
- The counter raster runs active first. h_cnt 0..H_ACTIVE-1 is active, then front porch, then sync at [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1], then back porch. v_cnt uses the same layout in lines.
- h_cnt wraps from H_TOTAL-1 to 0. v_cnt advances on that wrap and itself wraps from V_TOTAL-1 to 0.
- Stage-0 signals:
  - act = (h_cnt<H_ACTIVE) && (v_cnt<V_ACTIVE).
  - mem_rd = act.
  - hs0 and vs0 are decoded from the counters.
- Address generation:
  - mem_addr = (v_cnt>>SCALE_SHIFT)*(H_ACTIVE>>SCALE_SHIFT) + (h_cnt>>SCALE_SHIFT).
  - It is computed incrementally with a row-base register. No multiplier is used.
  - The row base advances by H_ACTIVE>>SCALE_SHIFT only when the low SCALE_SHIFT bits of v_cnt are all ones at the end of an active line.
  - The row base clears at frame_start.
  - The address is truncated to ADDR_W and wraps silently.
- Expansion: each 4-bit component is expanded to 8 bits by nibble duplication ({c,c}). 0xF maps to 0xFF and 0x0 maps to 0x00.
- out_data = 0 whenever out_de = 0.
- Sync polarity: when SYNC_POL = 0, a sync is driven low while asserted.
- frame_sync:
  - A frame_sync pulse forces h_cnt = H_TOTAL-1 and v_cnt = V_TOTAL-1 on the next edge, so the following cycle is frame_start.
  - If frame_sync arrives while the counters are already at that position, it has no extra effect. No double frame results.
  - A re-lock in mid-frame truncates that frame. mem_rd drops immediately.

## Timing
- Pipeline depth P = MEM_LAT+1. hs0, vs0 and act are delayed P cycles to produce out_hsync, out_vsync and out_de, so they align with expanded, registered mem_data.
- Latency from stage-0 act to out_de is exactly P cycles.
- frame_start is a stage-0 signal. It is not delayed.
- Reset values (all asserted immediately and asynchronously):
  - counters = 0
  - row base = 0
  - mem_rd = 0
  - mem_addr = 0
  - pipeline = inactive
  - out_de = 0
  - out_data = 0
  - out_hsync and out_vsync = deasserted (= ~SYNC_POL)
  - frame_start = 0
- First cycle after rst deasserts: h_cnt = 0, v_cnt = 0, mem_rd = 1, frame_start = 1.
- rst asserted mid-frame flushes the pipeline. No stale out_de survives reset.

## Configuration
- HDMI_TPG_EN
  - Defined: adds input tpg_sel (1 bit). When tpg_sel = 1, out_data is eight vertical colour bars, each H_ACTIVE/8 wide, in the order white, yellow, cyan, green, magenta, red, blue, black. The bars are aligned to out_de. mem_rd is forced to 0 while tpg_sel = 1. All timing is unchanged.
  - Undefined: the tpg_sel port and its logic are absent, and data comes only from memory.

## Test plan
- Defaults: the bench measures out_hsync period = 800 clk with a 96-clk low pulse, and out_vsync period = 420000 clk with a 1600-clk low pulse. out_de is high 640 clk per line on 480 lines.
- MEM_LAT = 3: mem_data returns the address+1 pattern. The first out_de cycle carries the expanded data for addr 0, exactly 4 cycles after mem_rd.
- SCALE_SHIFT = 1: each address repeats on 2 consecutive pixels. Lines 0 and 1 share the address range 0..319, line 2 starts at 320, and the last address is 76799.
- mem_data = 12'hF30 -> out_data = 24'hFF3300. out_data = 0 in blanking even with mem_data = 12'hFFF.
- frame_sync pulse at v_cnt = 100: the next cycle has frame_start = 1 and mem_addr = 0. A second pulse at frame end causes no extra frame.
- rst asserted mid-line for 3 cycles: all outputs reach their reset values at once, and frame_start = 1 on the first cycle after release.
